// File: rtl/ft_pkg.sv
// ft_pkg: shared types and helpers for the FT-style USB FIFO output path.
//   ft_word_t    - 32-bit bus word (also used by the capture input stage)
//   ft_state_t   - scheduler states IDLE / HDR / VIDEO / STATUS
//   BE_FULL      - byte-enable value driven with every loaded word
//   ft_hdr_word  - assembles the frame header word {tag, frame count}
package ft_pkg;

  typedef logic [31:0] ft_word_t;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    VIDEO,
    STATUS
  } ft_state_t;

  localparam logic [3:0] BE_FULL = 4'hF;

  function automatic ft_word_t ft_hdr_word(input logic [15:0] tag,
                                           input logic [15:0] cnt);
    return {tag, cnt};
  endfunction

endpackage

// File: rtl/ft_out_reg.sv
// ft_out_reg: single-entry output register driving the FT FIFO write bus.
// Ports:
//   CLK, rst    - clock, synchronous active-high reset
//   load        - load load_data this cycle (honoured only when load_ok)
//   load_data   - word to load
//   txe_n       - FIFO space flag (low = space)
//   load_ok     - register empty or draining this cycle
//   wr_n        - registered write strobe, active-low
//   data, be    - registered write data and byte enables
import ft_pkg::*;

module ft_out_reg (
  input  logic       CLK,
  input  logic       rst,
  input  logic       load,
  input  ft_word_t   load_data,
  input  logic       txe_n,
  output logic       load_ok,
  output logic       wr_n,
  output ft_word_t   data,
  output logic [3:0] be
);

  // A held word (wr_n=0) can only be replaced when the FIFO takes it.
  assign load_ok = wr_n | ~txe_n;

  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_n <= 1'b1;
      data <= '0;
      be   <= '0;
    end else if (load_ok) begin
      if (load) begin
        wr_n <= 1'b0;
        data <= load_data;
        be   <= BE_FULL;
      end else begin
        wr_n <= 1'b1;
        be   <= '0;
      end
    end
  end

endmodule

// File: rtl/ft_tx_scheduler.sv
// ft_tx_scheduler: shares the 32-bit FT FIFO write bus between the packed
// video word stream and single-word status messages, tags frames with a
// header word and throttles on txe_n through a one-entry output register.
// Parameters:
//   BURST_LEN - max consecutive video words before a pending status word wins
//   HDR_TAG   - upper half of the frame header word
// Ports:
//   CLK, rst                                  - clock, sync active-high reset
//   vid_data/vid_valid/vid_sof/vid_eof/vid_ready - video word stream
//   sts_data/sts_valid/sts_ready              - status word request
//   txe_n                                     - FIFO space flag (low = space)
//   wr_n, data, be                            - registered FIFO write bus
//   frame_cnt                                 - frames started (wraps)
//   drop_cnt                                  - stray video words (saturates)
// Build option: define FT_FRAME_HDR_EN to emit a header word per frame;
// without it the SOF word is consumed directly from IDLE.
import ft_pkg::*;

module ft_tx_scheduler #(
  parameter int          BURST_LEN = 64,
  parameter logic [15:0] HDR_TAG   = 16'hA5C3
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [31:0] vid_data,
  input  logic        vid_valid,
  input  logic        vid_sof,
  input  logic        vid_eof,
  output logic        vid_ready,
  input  logic [31:0] sts_data,
  input  logic        sts_valid,
  output logic        sts_ready,
  input  logic        txe_n,
  output logic        wr_n,
  output logic [31:0] data,
  output logic [3:0]  be,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);

  localparam int            BW        = $clog2(BURST_LEN + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);
  localparam logic [BW-1:0] BURST_PRE = BW'(BURST_LEN - 1);

  ft_state_t     state_q, state_d;
  logic [BW-1:0] burst_q;
  logic [15:0]   frame_q, drop_q;

  logic     load_ok, load;
  ft_word_t load_data;
  logic     frame_inc, drop_inc, burst_inc, burst_clr;
  logic     burst_full, burst_last, sof_restart;

`ifdef FT_FRAME_HDR_EN
  // Set by the header: the SOF flag of the next video word is expected and ignored.
  logic first_q, first_set, first_clr;
  assign sof_restart = vid_valid & vid_sof & ~first_q;
`else
  assign sof_restart = vid_valid & vid_sof;
`endif

  assign burst_full = (burst_q == BURST_MAX);
  assign burst_last = (burst_q == BURST_PRE);
  assign frame_cnt  = frame_q;
  assign drop_cnt   = drop_q;

  ft_out_reg u_out_reg (
    .CLK       (CLK),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .txe_n     (txe_n),
    .load_ok   (load_ok),
    .wr_n      (wr_n),
    .data      (data),
    .be        (be)
  );

  always_ff @(posedge CLK) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == STATUS && !sts_valid) begin
      state_d = VIDEO;
    end else if (load_ok) begin
      case (state_q)
        IDLE: begin
          if (!sts_valid && vid_valid && vid_sof) begin
`ifdef FT_FRAME_HDR_EN
            state_d = HDR;
`else
            state_d = vid_eof ? IDLE : VIDEO;
`endif
          end
        end
`ifdef FT_FRAME_HDR_EN
        HDR: state_d = VIDEO;
`endif
        VIDEO: begin
          if (sof_restart) begin
`ifdef FT_FRAME_HDR_EN
            state_d = HDR;
`else
            state_d = vid_eof ? IDLE : VIDEO;
`endif
          end else if (burst_full && sts_valid) begin
            state_d = STATUS;
          end else if (vid_valid) begin
            if (vid_eof)                      state_d = IDLE;
            else if (burst_last && sts_valid) state_d = STATUS;
          end else if (sts_valid) begin
            state_d = STATUS;
          end
        end
        STATUS:  state_d = VIDEO;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    vid_ready = 1'b0;
    sts_ready = 1'b0;
    load      = 1'b0;
    load_data = vid_data;
    frame_inc = 1'b0;
    drop_inc  = 1'b0;
    burst_inc = 1'b0;
    burst_clr = 1'b0;
`ifdef FT_FRAME_HDR_EN
    first_set = 1'b0;
    first_clr = 1'b0;
`endif
    if (load_ok) begin
      case (state_q)
        IDLE: begin
          if (sts_valid) begin
            sts_ready = 1'b1;
            load      = 1'b1;
            load_data = sts_data;
          end else if (vid_valid && vid_sof) begin
`ifndef FT_FRAME_HDR_EN
            vid_ready = 1'b1;
            load      = 1'b1;
            frame_inc = 1'b1;
            burst_clr = 1'b1;
            burst_inc = 1'b1;
`endif
          end else if (vid_valid) begin
            vid_ready = 1'b1;
            drop_inc  = 1'b1;
          end
        end
`ifdef FT_FRAME_HDR_EN
        HDR: begin
          load      = 1'b1;
          load_data = ft_hdr_word(HDR_TAG, frame_q);
          frame_inc = 1'b1;
          burst_clr = 1'b1;
          first_set = 1'b1;
        end
`endif
        VIDEO: begin
          if (sof_restart) begin
`ifndef FT_FRAME_HDR_EN
            // Without headers a mid-frame SOF simply starts the next frame.
            vid_ready = 1'b1;
            load      = 1'b1;
            frame_inc = 1'b1;
            burst_clr = 1'b1;
            burst_inc = 1'b1;
`endif
          end else if (!(burst_full && sts_valid) && vid_valid) begin
            vid_ready = 1'b1;
            load      = 1'b1;
            burst_inc = 1'b1;
`ifdef FT_FRAME_HDR_EN
            first_clr = 1'b1;
`endif
          end
        end
        STATUS: begin
          if (sts_valid) begin
            sts_ready = 1'b1;
            load      = 1'b1;
            load_data = sts_data;
            burst_clr = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      burst_q <= '0;
      frame_q <= '0;
      drop_q  <= '0;
`ifdef FT_FRAME_HDR_EN
      first_q <= 1'b0;
`endif
    end else begin
      // clr+inc together means a frame opened with its first word consumed.
      if (burst_clr)                   burst_q <= burst_inc ? BW'(1) : '0;
      else if (burst_inc && !burst_full) burst_q <= burst_q + BW'(1);
      if (frame_inc) frame_q <= frame_q + 16'd1;
      if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
`ifdef FT_FRAME_HDR_EN
      if (first_set)      first_q <= 1'b1;
      else if (first_clr) first_q <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_ft_tx_scheduler.sv
module tb_ft_tx_scheduler;

  logic        CLK = 1'b0;
  logic        rst;
  logic [31:0] vid_data;
  logic        vid_valid, vid_sof, vid_eof, vid_ready;
  logic [31:0] sts_data;
  logic        sts_valid, sts_ready;
  logic        txe_n, wr_n;
  logic [31:0] data;
  logic [3:0]  be;
  logic [15:0] frame_cnt, drop_cnt;

  always #5 CLK = ~CLK;

  ft_tx_scheduler #(.BURST_LEN(4), .HDR_TAG(16'hA5C3)) dut (
    .CLK(CLK), .rst(rst),
    .vid_data(vid_data), .vid_valid(vid_valid), .vid_sof(vid_sof),
    .vid_eof(vid_eof), .vid_ready(vid_ready),
    .sts_data(sts_data), .sts_valid(sts_valid), .sts_ready(sts_ready),
    .txe_n(txe_n), .wr_n(wr_n), .data(data), .be(be),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        sof;
    logic        eof;
  } vw_t;

  vw_t         vq[$];
  logic [31:0] sq[$];
  logic [31:0] exp_q[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc = 0;
  int          first_xfer, last_xfer, nx, nvr, watch_cnt;
  logic [31:0] watch_word = '1;
  logic [31:0] stall_word = '1;
  int          stall_left = 0;
  logic        txe_hold = 1'b0;
  logic [31:0] arm_word = '1;
  logic [31:0] arm_sts  = '0;
  logic [15:0] fexp = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    first_xfer = -1; last_xfer = 0; nx = 0; nvr = 0; watch_cnt = 0;
  endtask

  task automatic add_vid(input logic [31:0] d, input logic sof, input logic eof);
    vw_t w;
    w.d = d; w.sof = sof; w.eof = eof;
    vq.push_back(w);
  endtask

  // Header (when enabled) carries the frame count before the increment.
  task automatic frame_started();
`ifdef FT_FRAME_HDR_EN
    exp_q.push_back({16'hA5C3, fexp});
`endif
    fexp = fexp + 16'd1;
  endtask

  task automatic send_frame(input logic [31:0] base, input int n);
    frame_started();
    for (int i = 0; i < n; i++) begin
      add_vid(base + 32'(i), i == 0, i == n - 1);
      exp_q.push_back(base + 32'(i));
    end
  endtask

  task automatic step();
    logic vr, sr;
    if (vq.size() > 0) begin
      vid_valid = 1'b1; vid_data = vq[0].d; vid_sof = vq[0].sof; vid_eof = vq[0].eof;
    end else begin
      vid_valid = 1'b0; vid_data = '0; vid_sof = 1'b0; vid_eof = 1'b0;
    end
    if (sq.size() > 0) begin sts_valid = 1'b1; sts_data = sq[0]; end
    else begin sts_valid = 1'b0; sts_data = '0; end
    if (stall_left > 0 && wr_n === 1'b0 && data === stall_word) begin
      txe_n = 1'b1;
      stall_left--;
    end else begin
      txe_n = txe_hold;
    end
    @(negedge CLK);
    vr = vid_ready;
    sr = sts_ready;
    chk("ready_exclusive", {31'b0, vr & sr}, 32'd0);
    if (txe_n && !wr_n) chk("stall_no_consume", {31'b0, vr | sr}, 32'd0);
    if (!wr_n && data === watch_word) watch_cnt++;
    if (!wr_n && !txe_n) begin
      if (exp_q.size() == 0) begin
        chk("bus_unexpected_write", {31'b0, wr_n}, 32'd1);
      end else begin
        chk("bus_data", data, exp_q.pop_front());
        chk("bus_be", {28'b0, be}, 32'hF);
      end
      if (first_xfer < 0) first_xfer = cyc;
      last_xfer = cyc;
      nx++;
    end
    @(posedge CLK); #1;
    cyc++;
    if (vr) begin
      nvr++;
      if (vq.size() > 0) begin
        if (vq[0].d === arm_word) sq.push_back(arm_sts);
        void'(vq.pop_front());
      end
    end
    if (sr && sq.size() > 0) void'(sq.pop_front());
  endtask

  task automatic run(input string tag, input int max_cyc);
    int k = 0;
    while ((vq.size() > 0 || sq.size() > 0 || exp_q.size() > 0) && k < max_cyc) begin
      step();
      k++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b1; txe_n = 1'b0;
    vid_valid = 1'b0; vid_data = '0; vid_sof = 1'b0; vid_eof = 1'b0;
    sts_valid = 1'b0; sts_data = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_wr_n", {31'b0, wr_n}, 32'd1);
    chk("rst_data", data, 32'd0);
    chk("rst_be", {28'b0, be}, 32'd0);
    chk("rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
    chk("rst_drop_cnt", {16'b0, drop_cnt}, 32'd0);
    chk("rst_vid_ready", {31'b0, vid_ready}, 32'd0);
    rst = 1'b0;

    // Single 4-word frame on consecutive cycles.
    clr_stats();
    send_frame(32'hD000_0000, 4);
    run("single_drained", 40);
`ifdef FT_FRAME_HDR_EN
    chk("single_words", 32'(nx), 32'd5);
`else
    chk("single_words", 32'(nx), 32'd4);
`endif
    chk("single_span", 32'(last_xfer - first_xfer), 32'(nx - 1));
    chk("single_frame_cnt", {16'b0, frame_cnt}, {16'b0, fexp});

    // Status word granted from IDLE.
    clr_stats();
    sq.push_back(32'h5A5A_0001);
    exp_q.push_back(32'h5A5A_0001);
    run("idle_status_drained", 20);
    chk("idle_status_words", 32'(nx), 32'd1);

    // Back-pressure: txe_n high 3 cycles while E1 is held.
    clr_stats();
    send_frame(32'hE000_0000, 4);
    stall_word = 32'hE000_0001; stall_left = 3; watch_word = 32'hE000_0001;
    run("stall_drained", 40);
    chk("stall_e1_cycles", 32'(watch_cnt), 32'd4);
    chk("stall_span", 32'(last_xfer - first_xfer), 32'(nx - 1 + 3));
    chk("stall_frame_cnt", {16'b0, frame_cnt}, {16'b0, fexp});
    watch_word = '1; stall_word = '1;

    // Burst arbitration: S0 appears after W0, wins after 4 video words.
    clr_stats();
    frame_started();
    for (int i = 0; i < 10; i++) add_vid(32'hB000_0000 + 32'(i), i == 0, i == 9);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hB000_0000 + 32'(i));
    exp_q.push_back(32'h5000_0000);
    for (int i = 4; i < 10; i++) exp_q.push_back(32'hB000_0000 + 32'(i));
    arm_word = 32'hB000_0000; arm_sts = 32'h5000_0000;
    run("burst_drained", 60);
    chk("burst_span", 32'(last_xfer - first_xfer), 32'(nx - 1));
    chk("burst_frame_cnt", {16'b0, frame_cnt}, {16'b0, fexp});
    arm_word = '1;

    // Stray words outside a frame are dropped.
    clr_stats();
    for (int i = 0; i < 3; i++) add_vid(32'hC000_0000 + 32'(i), 1'b0, 1'b0);
    repeat (3) step();
    chk("stray_ready", 32'(nvr), 32'd3);
    chk("stray_left", 32'(vq.size()), 32'd0);
    chk("stray_drop_cnt", {16'b0, drop_cnt}, 32'd3);
    repeat (2) step();
    chk("stray_bus_idle", 32'(nx), 32'd0);

    // Missing EOF: second SOF opens a new frame.
    clr_stats();
    frame_started();
    add_vid(32'hA000_0000, 1'b1, 1'b0); exp_q.push_back(32'hA000_0000);
    add_vid(32'hA000_0001, 1'b0, 1'b0); exp_q.push_back(32'hA000_0001);
    frame_started();
    add_vid(32'hA100_0000, 1'b1, 1'b0); exp_q.push_back(32'hA100_0000);
    add_vid(32'hA100_0001, 1'b0, 1'b1); exp_q.push_back(32'hA100_0001);
    run("noeof_drained", 40);
    chk("noeof_frame_cnt", {16'b0, frame_cnt}, {16'b0, fexp});

    // Frame counter wrap FFFF -> 0000.
    force dut.frame_q = 16'hFFFF;
    @(posedge CLK); #1;
    release dut.frame_q;
    fexp = 16'hFFFF;
    clr_stats();
    send_frame(32'hF000_0000, 1);
    run("wrap_drained", 20);
    chk("wrap_frame_cnt", {16'b0, frame_cnt}, 32'd0);
    send_frame(32'hF100_0000, 2);
    run("wrap2_drained", 20);
    chk("wrap2_frame_cnt", {16'b0, frame_cnt}, 32'd1);

    // Reset mid-frame with a word held in the output register.
    send_frame(32'h7000_0000, 6);
    txe_hold = 1'b0;
    repeat (4) step();
    txe_hold = 1'b1;
    repeat (2) step();
    chk("midrst_held", {31'b0, wr_n}, 32'd0);
    vq.delete(); sq.delete(); exp_q.delete();
    vid_valid = 1'b0; sts_valid = 1'b0;
    rst = 1'b1;
    @(posedge CLK); #1;
    chk("midrst_wr_n", {31'b0, wr_n}, 32'd1);
    chk("midrst_be", {28'b0, be}, 32'd0);
    chk("midrst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
    chk("midrst_drop_cnt", {16'b0, drop_cnt}, 32'd0);
    rst = 1'b0; txe_hold = 1'b0; fexp = '0;

    // Clean frame after reset restarts numbering from 0.
    clr_stats();
    send_frame(32'h9000_0000, 3);
    run("post_rst_drained", 30);
    chk("post_rst_frame_cnt", {16'b0, frame_cnt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
